// File: rtl/vram_pkg.sv
// Shared types and default sizes for the VRAM write-port arbiter and its fill engine.
package vram_pkg;

  localparam int VRAM_ADDR_W  = 11;
  localparam int VRAM_COUNT_W = 12;
  localparam int VRAM_WORDS   = 2048;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  typedef enum logic {
    GNT_HOST = 1'b0,
    GNT_FILL = 1'b1
  } grant_t;

endpackage

// File: rtl/vram_write_arbiter_if.sv
// Host, fill-control and VRAM write-port bundle; slave is the arbiter, master drives requests.
interface vram_write_arbiter_if
  import vram_pkg::*;
#(
  parameter int ADDR_W  = VRAM_ADDR_W,
  parameter int COUNT_W = VRAM_COUNT_W
) ();

  logic               HOST_WRITE;
  logic [ADDR_W-1:0]  HOST_ADDR;
  logic [3:0]         HOST_BYTE_EN;
  logic [31:0]        HOST_WRITEDATA;
  logic               HOST_WAITREQUEST;

  logic               FILL_START;
  logic [ADDR_W-1:0]  FILL_BASE;
  logic [COUNT_W-1:0] FILL_COUNT;
  logic [31:0]        FILL_DATA;
  logic               FILL_BUSY;
  logic               FILL_DONE;

  logic               VRAM_WREN;
  logic [ADDR_W-1:0]  VRAM_WRADDR;
  logic [3:0]         VRAM_BYTEEN;
  logic [31:0]        VRAM_DATA;

  modport master (
    output HOST_WRITE, HOST_ADDR, HOST_BYTE_EN, HOST_WRITEDATA,
    output FILL_START, FILL_BASE, FILL_COUNT, FILL_DATA,
    input  HOST_WAITREQUEST, FILL_BUSY, FILL_DONE,
    input  VRAM_WREN, VRAM_WRADDR, VRAM_BYTEEN, VRAM_DATA
  );

  modport slave (
    input  HOST_WRITE, HOST_ADDR, HOST_BYTE_EN, HOST_WRITEDATA,
    input  FILL_START, FILL_BASE, FILL_COUNT, FILL_DATA,
    output HOST_WAITREQUEST, FILL_BUSY, FILL_DONE,
    output VRAM_WREN, VRAM_WRADDR, VRAM_BYTEEN, VRAM_DATA
  );

endinterface

// File: rtl/vram_fill_engine.sv
// Range-fill engine: walks base..base+count-1 (mod 2^ADDR_W), one word per grant.
// IDLE | waiting for start   RUN | requesting, one word per grant   DONE | one-cycle completion pulse
module vram_fill_engine
  import vram_pkg::*;
#(
  parameter int ADDR_W  = VRAM_ADDR_W,
  parameter int COUNT_W = VRAM_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base,
  input  logic [COUNT_W-1:0] count,
  input  logic [31:0]        fill_word,
  input  logic               gnt,
  output logic               req,
  output logic [ADDR_W-1:0]  addr,
  output logic [31:0]        data,
  output logic               busy,
  output logic               done
);

  localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(1 << ADDR_W);
  localparam logic [COUNT_W-1:0] ONE_LEFT  = COUNT_W'(1);

  fill_state_t        state;
  logic [COUNT_W-1:0] remain;

  assign req = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr   <= '0;
      remain <= '0;
      data   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            addr <= base;
            data <= fill_word;
            busy <= 1'b1;
            if (count == '0) begin
              remain <= '0;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              // a full-screen fill is the most that makes sense; longer requests are clamped
              remain <= (count > MAX_COUNT) ? MAX_COUNT : count;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (gnt) begin
            addr   <= addr + 1'b1;
            remain <= remain - 1'b1;
            if (remain == ONE_LEFT) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/vram_write_arbiter.sv
// Shares the VRAM write port between host writes and the fill engine; registered write port.
// VRAM_ARB_FAIR_EN defined: round-robin on contention; undefined: strict host priority.
module vram_write_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W  = VRAM_ADDR_W,
  parameter int COUNT_W = VRAM_COUNT_W
) (
  input logic                 CLK,
  input logic                 RESET,
  vram_write_arbiter_if.slave bus
);

  logic              fill_req;
  logic              fill_gnt;
  logic              host_gnt;
  logic [ADDR_W-1:0] fill_addr;
  logic [31:0]       fill_data;

  vram_fill_engine #(
    .ADDR_W  (ADDR_W),
    .COUNT_W (COUNT_W)
  ) u_fill (
    .clk       (CLK),
    .rst       (RESET),
    .start     (bus.FILL_START),
    .base      (bus.FILL_BASE),
    .count     (bus.FILL_COUNT),
    .fill_word (bus.FILL_DATA),
    .gnt       (fill_gnt),
    .req       (fill_req),
    .addr      (fill_addr),
    .data      (fill_data),
    .busy      (bus.FILL_BUSY),
    .done      (bus.FILL_DONE)
  );

`ifdef VRAM_ARB_FAIR_EN
  grant_t last_grant;

  // on contention the side that did not win last time goes first
  assign fill_gnt             = fill_req && (!bus.HOST_WRITE || last_grant == GNT_HOST);
  assign bus.HOST_WAITREQUEST = bus.HOST_WRITE && fill_gnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_grant <= GNT_HOST;
    end else if (host_gnt) begin
      last_grant <= GNT_HOST;
    end else if (fill_gnt) begin
      last_grant <= GNT_FILL;
    end
  end
`else
  // host always wins; a busy host simply parks the fill in RUN
  assign fill_gnt             = fill_req && !bus.HOST_WRITE;
  assign bus.HOST_WAITREQUEST = 1'b0;
`endif

  assign host_gnt = bus.HOST_WRITE && !fill_gnt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus.VRAM_WREN   <= 1'b0;
      bus.VRAM_WRADDR <= '0;
      bus.VRAM_BYTEEN <= 4'h0;
      bus.VRAM_DATA   <= '0;
    end else if (host_gnt) begin
      bus.VRAM_WREN   <= 1'b1;
      bus.VRAM_WRADDR <= bus.HOST_ADDR;
      bus.VRAM_BYTEEN <= bus.HOST_BYTE_EN;
      bus.VRAM_DATA   <= bus.HOST_WRITEDATA;
    end else if (fill_gnt) begin
      bus.VRAM_WREN   <= 1'b1;
      bus.VRAM_WRADDR <= fill_addr;
      bus.VRAM_BYTEEN <= 4'hF;
      bus.VRAM_DATA   <= fill_data;
    end else begin
      bus.VRAM_WREN   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Scoreboard bench for vram_write_arbiter: expected writes queued at issue, popped by a write monitor.
module tb_vram_write_arbiter;
  import vram_pkg::*;

  localparam int AW    = 11;
  localparam int CW    = 12;
  localparam int WORDS = 2048;

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  vram_write_arbiter_if #(.ADDR_W(AW), .COUNT_W(CW)) bus ();

  vram_write_arbiter #(.ADDR_W(AW), .COUNT_W(CW)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  wr_t host_q[$];
  wr_t fill_q[$];
  int  compared = 0;
  int  mismatched = 0;
  int  cyc = 0;
  int  fill_wr = 0;
  int  host_wr = 0;
  int  done_cnt = 0;
  int  last_done_cyc = 0;
  int  waitreq_seen = 0;
  int  start_cyc = 0;
  bit  fill_active = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void check_le(input string name, input int act, input int lim);
    compared++;
    if (act > lim) begin
      mismatched++;
      $display("FAIL %s: got %0d expected at most %0d", name, act, lim);
    end
  endfunction

  function automatic bit wr_match(input wr_t w);
    return (bus.VRAM_WRADDR === w.addr) && (bus.VRAM_BYTEEN === w.be) && (bus.VRAM_DATA === w.data);
  endfunction

  // write monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.HOST_WAITREQUEST === 1'b1) waitreq_seen++;
      if (bus.VRAM_WREN === 1'b1) begin
        compared++;
        if (host_q.size() > 0 && wr_match(host_q[0])) begin
          void'(host_q.pop_front());
          host_wr++;
        end else if (fill_q.size() > 0 && wr_match(fill_q[0])) begin
          void'(fill_q.pop_front());
          fill_wr++;
        end else begin
          mismatched++;
          $display("FAIL vram_write: got addr=%0d be=%h data=%h, required next host/fill write not matched (host pending %0d, fill pending %0d)",
                   bus.VRAM_WRADDR, bus.VRAM_BYTEEN, bus.VRAM_DATA, host_q.size(), fill_q.size());
        end
      end
      if (bus.FILL_DONE === 1'b1) begin
        check("done_while_active", fill_active, 1);
        check("done_fill_drained", fill_q.size(), 0);
        done_cnt++;
        last_done_cyc = cyc;
        fill_active = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // every task below starts and ends 1 time unit after a rising edge
  task automatic fill_start(input int base, input int count, input logic [31:0] d);
    int n;
    bus.FILL_BASE  = AW'(base);
    bus.FILL_COUNT = CW'(count);
    bus.FILL_DATA  = d;
    bus.FILL_START = 1'b1;
    start_cyc = cyc;
    if (!fill_active) begin
      n = (count > WORDS) ? WORDS : count;
      for (int i = 0; i < n; i++)
        fill_q.push_back('{addr: AW'((base + i) % WORDS), be: 4'hF, data: d});
      fill_active = 1'b1;
    end
    @(posedge clk); #1;
    bus.FILL_START = 1'b0;
  endtask

  task automatic host_seq(input int n, input int max_gap, output int max_wait);
    int g;
    int w;
    bit acc;
    max_wait = 0;
    for (int i = 0; i < n; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      bus.HOST_WRITE = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      bus.HOST_ADDR      = AW'($urandom);
      bus.HOST_BYTE_EN   = 4'($urandom_range(15, 1));
      bus.HOST_WRITEDATA = {8'hA5, 24'($urandom)};
      bus.HOST_WRITE     = 1'b1;
      w = 0;
      acc = 1'b0;
      while (!acc && w < 50) begin
        @(negedge clk);
        if (bus.HOST_WAITREQUEST !== 1'b1) begin
          acc = 1'b1;
          host_q.push_back('{addr: bus.HOST_ADDR, be: bus.HOST_BYTE_EN, data: bus.HOST_WRITEDATA});
        end else begin
          w++;
        end
        @(posedge clk); #1;
      end
      if (!acc) begin
        compared++;
        mismatched++;
        $display("FAIL host_accept: got no acceptance within 50 cycles, required acceptance");
      end
      if (w > max_wait) max_wait = w;
    end
    bus.HOST_WRITE = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int w = 0;
    while (fill_active && w < budget) begin
      @(negedge clk); #1;
      w++;
    end
    check(name, fill_active, 0);
    @(posedge clk); #1;
  endtask

  int s, f0, h0, d0, mw, base, count;

  initial begin
    bus.HOST_WRITE = 1'b0;
    bus.HOST_ADDR = '0;
    bus.HOST_BYTE_EN = 4'h0;
    bus.HOST_WRITEDATA = '0;
    bus.FILL_START = 1'b0;
    bus.FILL_BASE = '0;
    bus.FILL_COUNT = '0;
    bus.FILL_DATA = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wren", bus.VRAM_WREN, 0);
    check("rst_wraddr", bus.VRAM_WRADDR, 0);
    check("rst_byteen", bus.VRAM_BYTEEN, 0);
    check("rst_data", bus.VRAM_DATA, 0);
    check("rst_busy", bus.FILL_BUSY, 0);
    check("rst_done", bus.FILL_DONE, 0);
    check("rst_waitreq", bus.HOST_WAITREQUEST, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // long uncontended fill
    f0 = fill_wr;
    fill_start(0, 1200, 32'h0020_0020);
    s = start_cyc;
    wait_done(1300, "fill1200_done");
    check("fill1200_latency", last_done_cyc - s, 1201);
    check("fill1200_writes", fill_wr - f0, 1200);

    // wrap-around at the top of VRAM
    f0 = fill_wr;
    fill_start(2046, 4, 32'h5A5A_0001);
    s = start_cyc;
    wait_done(20, "wrap_done");
    check("wrap_latency", last_done_cyc - s, 5);
    check("wrap_writes", fill_wr - f0, 4);

    // oversize count is clamped to a full screen
    f0 = fill_wr;
    fill_start(1000, 4095, 32'h5A00_0003);
    s = start_cyc;
    wait_done(2200, "clamp_done");
    check("clamp_latency", last_done_cyc - s, WORDS + 1);
    check("clamp_writes", fill_wr - f0, WORDS);

    // zero-length fill
    f0 = fill_wr;
    fill_start(123, 0, 32'h5A00_0004);
    s = start_cyc;
    @(negedge clk);
    check("zero_busy_hi", bus.FILL_BUSY, 1);
    check("zero_done_hi", bus.FILL_DONE, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("zero_busy_lo", bus.FILL_BUSY, 0);
    check("zero_done_lo", bus.FILL_DONE, 0);
    @(posedge clk); #1;
    check("zero_writes", fill_wr - f0, 0);
    check("zero_latency", last_done_cyc - s, 1);

    // second start while running is ignored
    f0 = fill_wr;
    fill_start(300, 20, 32'h5A00_0005);
    s = start_cyc;
    repeat (5) begin @(posedge clk); #1; end
    fill_start(900, 5, 32'h5A00_0006);
    wait_done(60, "ignored_start_done");
    check("ignored_start_latency", last_done_cyc - s, 21);
    check("ignored_start_writes", fill_wr - f0, 20);

`ifdef VRAM_ARB_FAIR_EN
    // continuous host stream against a 10-word fill
    f0 = fill_wr;
    h0 = host_wr;
    fork
      host_seq(16, 0, mw);
      begin
        repeat (2) begin @(posedge clk); #1; end
        fill_start(700, 10, 32'h5A00_0010);
        s = start_cyc;
      end
    join
    wait_done(40, "contention_done");
    check_le("contention_latency", last_done_cyc - s, 20);
    check_le("contention_host_wait", mw, 1);
    repeat (2) begin @(posedge clk); #1; end
    check("contention_fill_writes", fill_wr - f0, 10);
    check("contention_host_writes", host_wr - h0, 16);
`else
    // host stream parks the fill; it resumes where it stopped
    f0 = fill_wr;
    h0 = host_wr;
    fill_start(700, 10, 32'h5A00_0010);
    s = start_cyc;
    repeat (3) begin @(posedge clk); #1; end
    host_seq(30, 0, mw);
    check("strict_fill_stalled", fill_wr - f0, 3);
    wait_done(40, "strict_done");
    check("strict_latency", last_done_cyc - s, 41);
    check("strict_fill_writes", fill_wr - f0, 10);
    check("strict_host_writes", host_wr - h0, 30);
    check("strict_waitreq_seen", waitreq_seen, 0);
    check("strict_host_wait", mw, 0);
`endif

    // reset in the middle of a fill
    f0 = fill_wr;
    fill_start(100, 100, 32'h5A00_0020);
    begin
      int w = 0;
      while ((fill_wr - f0) < 5 && w < 50) begin
        @(negedge clk); #1;
        w++;
      end
    end
    check("reset_word5_reached", (fill_wr - f0) >= 5, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fill_q.delete();
    fill_active = 1'b0;
    d0 = done_cnt;
    f0 = fill_wr;
    @(negedge clk);
    check("abort_wren", bus.VRAM_WREN, 0);
    check("abort_wraddr", bus.VRAM_WRADDR, 0);
    check("abort_byteen", bus.VRAM_BYTEEN, 0);
    check("abort_data", bus.VRAM_DATA, 0);
    check("abort_busy", bus.FILL_BUSY, 0);
    check("abort_done", bus.FILL_DONE, 0);
    check("abort_waitreq", bus.HOST_WAITREQUEST, 0);
    @(posedge clk); #1;
    repeat (120) begin @(posedge clk); #1; end
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_writes", fill_wr - f0, 0);

    // randomized fills with sporadic host traffic
    for (int it = 0; it < 8; it++) begin
      base = int'($urandom_range(WORDS - 1, 0));
      count = int'($urandom_range(40, 0));
      fork
        host_seq(int'($urandom_range(12, 0)), 3, mw);
        fill_start(base, count, {8'h5A, 24'($urandom)});
      join
      wait_done(400, "random_done");
      check_le("random_host_wait", mw, 1);
    end

    repeat (3) begin @(posedge clk); #1; end
    check("final_host_q_empty", host_q.size(), 0);
    check("final_fill_q_empty", fill_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
